axi4_txn_gate: RTL and testbench

- Handshake controller between the Rocket memory master and the address-remapped AXI4 memory port.
- Counts outstanding write and read transactions and caps each at a programmable limit.
- On request, closes the AW/AR channels, waits for all in-flight transactions to complete, then reports halted. This lets software or board logic safely reconfigure or reset the memory side.
- Only valid/ready/last signals pass through the block; payload buses are wired around it.

---
 rtl/axi4_txn_gate.sv | 160 ++++++++++++++++
 tb/tb_axi4_txn_gate.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_txn_gate.sv
// rtl/axi4_txn_gate.sv - outstanding-transaction limiter and drain gate for an AXI4 memory port
// Only handshake controls pass through; payload buses are wired around this block.
module axi4_txn_gate #(
  parameter int C_MAX_OUTSTANDING = 16,
  parameter int C_CNT_BITS        = 5
) (
  input  logic                  clk,
  input  logic                  aresetn,
  input  logic                  s_aw_valid,
  output logic                  s_aw_ready,
  output logic                  m_aw_valid,
  input  logic                  m_aw_ready,
  input  logic                  s_ar_valid,
  output logic                  s_ar_ready,
  output logic                  m_ar_valid,
  input  logic                  m_ar_ready,
  input  logic                  b_valid,
  input  logic                  b_ready,
  input  logic                  r_valid,
  input  logic                  r_ready,
  input  logic                  r_last,
  input  logic                  drain_req,
  output logic                  halted,
  output logic [C_CNT_BITS-1:0] wr_outstanding,
  output logic [C_CNT_BITS-1:0] rd_outstanding,
  output logic                  err_underflow
);

  localparam logic [C_CNT_BITS-1:0] MAX_CNT = C_CNT_BITS'(C_MAX_OUTSTANDING);
  localparam logic [C_CNT_BITS-1:0] CNT_ONE = C_CNT_BITS'(1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t                state;
  state_t                state_nxt;
  logic [C_CNT_BITS-1:0] wr_cnt;
  logic [C_CNT_BITS-1:0] wr_cnt_nxt;
  logic [C_CNT_BITS-1:0] rd_cnt;
  logic [C_CNT_BITS-1:0] rd_cnt_nxt;
  logic                  aw_held;
  logic                  ar_held;
  logic                  aw_held_nxt;
  logic                  ar_held_nxt;
  logic                  halted_q;
  logic                  err_q;
  logic                  aw_open;
  logic                  ar_open;
  logic                  aw_fire;
  logic                  ar_fire;
  logic                  b_fire;
  logic                  r_fire;
  logic                  wr_under;
  logic                  rd_under;
  logic                  port_idle_nxt;

  // A request already presented downstream stays open until it handshakes,
  // so AXI valid stability holds across drain and limit changes.
  assign aw_open = aw_held | ((state == ST_RUN) & (wr_cnt < MAX_CNT));
  assign ar_open = ar_held | ((state == ST_RUN) & (rd_cnt < MAX_CNT));

  assign m_aw_valid = s_aw_valid & aw_open;
  assign s_aw_ready = m_aw_ready & aw_open;
  assign m_ar_valid = s_ar_valid & ar_open;
  assign s_ar_ready = m_ar_ready & ar_open;

  assign aw_fire = m_aw_valid & m_aw_ready;
  assign ar_fire = m_ar_valid & m_ar_ready;
  assign b_fire  = b_valid & b_ready;
  assign r_fire  = r_valid & r_ready & r_last;

  assign aw_held_nxt = m_aw_valid & ~m_aw_ready;
  assign ar_held_nxt = m_ar_valid & ~m_ar_ready;

  always_comb begin
    wr_cnt_nxt = wr_cnt;
    wr_under   = 1'b0;
    if (aw_fire && !b_fire) begin
      wr_cnt_nxt = wr_cnt + CNT_ONE;
    end else if (b_fire && !aw_fire) begin
      if (wr_cnt == '0) begin
        wr_under = 1'b1;
      end else begin
        wr_cnt_nxt = wr_cnt - CNT_ONE;
      end
    end
  end

  always_comb begin
    rd_cnt_nxt = rd_cnt;
    rd_under   = 1'b0;
    if (ar_fire && !r_fire) begin
      rd_cnt_nxt = rd_cnt + CNT_ONE;
    end else if (r_fire && !ar_fire) begin
      if (rd_cnt == '0) begin
        rd_under = 1'b1;
      end else begin
        rd_cnt_nxt = rd_cnt - CNT_ONE;
      end
    end
  end

  // Idleness is judged on next-cycle values so HALT is entered on the edge
  // that retires the last response.
  assign port_idle_nxt = (wr_cnt_nxt == '0) & (rd_cnt_nxt == '0) &
                         ~aw_held_nxt & ~ar_held_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN: begin
        if (drain_req) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!drain_req) begin
          state_nxt = ST_RUN;
        end else if (port_idle_nxt) begin
          state_nxt = ST_HALT;
        end
      end
      ST_HALT: begin
        if (!drain_req) begin
          state_nxt = ST_RUN;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!aresetn) begin
      state    <= ST_RUN;
      wr_cnt   <= '0;
      rd_cnt   <= '0;
      aw_held  <= 1'b0;
      ar_held  <= 1'b0;
      halted_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      wr_cnt   <= wr_cnt_nxt;
      rd_cnt   <= rd_cnt_nxt;
      aw_held  <= aw_held_nxt;
      ar_held  <= ar_held_nxt;
      halted_q <= (state_nxt == ST_HALT);
      err_q    <= err_q | wr_under | rd_under;
    end
  end

  assign halted         = halted_q;
  assign err_underflow  = err_q;
  assign wr_outstanding = wr_cnt;
  assign rd_outstanding = rd_cnt;

endmodule

// File: tb/tb_axi4_txn_gate.sv
// tb/tb_axi4_txn_gate.sv - directed bench for axi4_txn_gate with a transaction-level reference model
// Two instances (limit 16 and limit 2) share one stimulus stream.
module tb_axi4_txn_gate;

  logic clk = 1'b0;
  logic aresetn = 1'b0;
  logic s_aw_valid = 1'b0, m_aw_ready = 1'b0;
  logic s_ar_valid = 1'b0, m_ar_ready = 1'b0;
  logic b_valid = 1'b0, b_ready = 1'b0;
  logic r_valid = 1'b0, r_ready = 1'b0, r_last = 1'b0;
  logic drain_req = 1'b0;

  logic [1:0] s_aw_ready_o, m_aw_valid_o, s_ar_ready_o, m_ar_valid_o;
  logic [1:0] halted_o, err_o;
  logic [4:0] wr_o [2];
  logic [4:0] rd_o [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi4_txn_gate #(.C_MAX_OUTSTANDING(16), .C_CNT_BITS(5)) u_dut16 (
    .clk(clk), .aresetn(aresetn),
    .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready_o[0]),
    .m_aw_valid(m_aw_valid_o[0]), .m_aw_ready(m_aw_ready),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready_o[0]),
    .m_ar_valid(m_ar_valid_o[0]), .m_ar_ready(m_ar_ready),
    .b_valid(b_valid), .b_ready(b_ready),
    .r_valid(r_valid), .r_ready(r_ready), .r_last(r_last),
    .drain_req(drain_req), .halted(halted_o[0]),
    .wr_outstanding(wr_o[0]), .rd_outstanding(rd_o[0]),
    .err_underflow(err_o[0])
  );

  axi4_txn_gate #(.C_MAX_OUTSTANDING(2), .C_CNT_BITS(5)) u_dut2 (
    .clk(clk), .aresetn(aresetn),
    .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready_o[1]),
    .m_aw_valid(m_aw_valid_o[1]), .m_aw_ready(m_aw_ready),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready_o[1]),
    .m_ar_valid(m_ar_valid_o[1]), .m_ar_ready(m_ar_ready),
    .b_valid(b_valid), .b_ready(b_ready),
    .r_valid(r_valid), .r_ready(r_ready), .r_last(r_last),
    .drain_req(drain_req), .halted(halted_o[1]),
    .wr_outstanding(wr_o[1]), .rd_outstanding(rd_o[1]),
    .err_underflow(err_o[1])
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: per instance, in-flight write/read counts, whether a
  // presented request is still pending, and whether the port is running,
  // draining or parked.
  int  lim [2] = '{16, 2};
  int  wc [2], rc [2];
  bit  awp [2], arp [2], err [2];
  bit  draining [2], parked [2];
  bit  mvalid = 1'b0;
  bit  awo, aro, ev_aw, ev_ar, aw_hs, ar_hs, b_hs, r_hs;

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      awo   = awp[k] || (!draining[k] && !parked[k] && wc[k] < lim[k]);
      aro   = arp[k] || (!draining[k] && !parked[k] && rc[k] < lim[k]);
      ev_aw = s_aw_valid && awo;
      ev_ar = s_ar_valid && aro;
      if (mvalid) begin
        chk($sformatf("m_aw_valid[%0d]", k), int'(m_aw_valid_o[k]), int'(ev_aw));
        chk($sformatf("s_aw_ready[%0d]", k), int'(s_aw_ready_o[k]), int'(m_aw_ready && awo));
        chk($sformatf("m_ar_valid[%0d]", k), int'(m_ar_valid_o[k]), int'(ev_ar));
        chk($sformatf("s_ar_ready[%0d]", k), int'(s_ar_ready_o[k]), int'(m_ar_ready && aro));
        chk($sformatf("halted[%0d]", k), int'(halted_o[k]), int'(parked[k]));
        chk($sformatf("wr_outstanding[%0d]", k), int'(wr_o[k]), wc[k]);
        chk($sformatf("rd_outstanding[%0d]", k), int'(rd_o[k]), rc[k]);
        chk($sformatf("err_underflow[%0d]", k), int'(err_o[k]), int'(err[k]));
      end
      if (!aresetn) begin
        wc[k] = 0; rc[k] = 0; awp[k] = 0; arp[k] = 0; err[k] = 0;
        draining[k] = 0; parked[k] = 0;
      end else if (mvalid) begin
        aw_hs = ev_aw && m_aw_ready;
        ar_hs = ev_ar && m_ar_ready;
        b_hs  = b_valid && b_ready;
        r_hs  = r_valid && r_ready && r_last;
        if (aw_hs && !b_hs) wc[k]++;
        else if (b_hs && !aw_hs) begin
          if (wc[k] == 0) err[k] = 1; else wc[k]--;
        end
        if (ar_hs && !r_hs) rc[k]++;
        else if (r_hs && !ar_hs) begin
          if (rc[k] == 0) err[k] = 1; else rc[k]--;
        end
        awp[k] = ev_aw && !m_aw_ready;
        arp[k] = ev_ar && !m_ar_ready;
        if (!drain_req) begin
          draining[k] = 0; parked[k] = 0;
        end else if (draining[k] && wc[k] == 0 && rc[k] == 0 && !awp[k] && !arp[k]) begin
          draining[k] = 0; parked[k] = 1;
        end else if (!parked[k]) begin
          draining[k] = 1;
        end
      end
    end
    if (!aresetn) mvalid = 1'b1;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    s_aw_valid = 0; m_aw_ready = 0; s_ar_valid = 0; m_ar_ready = 0;
    b_valid = 0; b_ready = 0; r_valid = 0; r_ready = 0; r_last = 0;
    drain_req = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    aresetn = 0;
    cyc();
    cyc();
    aresetn = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();
    settle();
    chk("reset halted", int'(halted_o[0]), 0);
    chk("reset wr", int'(wr_o[0]), 0);
    chk("reset err", int'(err_o[0]), 0);

    // Basic counting
    s_aw_valid = 1; m_aw_ready = 1;
    settle();
    chk("basic s_aw_ready", int'(s_aw_ready_o[0]), 1);
    for (int i = 1; i <= 3; i++) begin
      cyc();
      chk($sformatf("basic wr up %0d", i), int'(wr_o[0]), i);
    end
    s_aw_valid = 0; m_aw_ready = 0; b_valid = 1; b_ready = 1;
    for (int i = 2; i >= 0; i--) begin
      cyc();
      chk($sformatf("basic wr down %0d", i), int'(wr_o[0]), i);
    end
    b_valid = 0; b_ready = 0;
    chk("basic err", int'(err_o[0]), 0);
    chk("basic lim2 capped err", int'(err_o[1]), 1);

    // Limit on the 2-deep instance
    do_reset();
    s_ar_valid = 1; m_ar_ready = 1;
    settle();
    chk("limit s_ar_ready first", int'(s_ar_ready_o[1]), 1);
    cyc(); cyc();
    chk("limit rd at cap", int'(rd_o[1]), 2);
    chk("limit s_ar_ready closed", int'(s_ar_ready_o[1]), 0);
    chk("limit m_ar_valid closed", int'(m_ar_valid_o[1]), 0);
    r_valid = 1; r_ready = 1; r_last = 0;
    cyc();
    chk("limit non-last beat", int'(rd_o[1]), 2);
    r_last = 1;
    cyc();
    chk("limit last beat", int'(rd_o[1]), 1);
    r_valid = 0; r_ready = 0; r_last = 0;
    settle();
    chk("limit reopened", int'(s_ar_ready_o[1]), 1);
    cyc();
    chk("limit third accepted", int'(rd_o[1]), 2);
    s_ar_valid = 0; m_ar_ready = 0;

    // Drain with traffic
    do_reset();
    s_aw_valid = 1; m_aw_ready = 1;
    cyc(); cyc();
    chk("drain wr 2", int'(wr_o[0]), 2);
    s_aw_valid = 0; m_aw_ready = 0; drain_req = 1;
    cyc();
    s_aw_valid = 1; m_aw_ready = 1;
    settle();
    chk("drain aw refused valid", int'(m_aw_valid_o[0]), 0);
    chk("drain aw refused ready", int'(s_aw_ready_o[0]), 0);
    b_valid = 1; b_ready = 1;
    cyc(); cyc();
    b_valid = 0; b_ready = 0;
    chk("drain wr 0", int'(wr_o[0]), 0);
    for (int n = 0; n < 2 && halted_o[0] !== 1'b1; n++) cyc();
    chk("drain halted", int'(halted_o[0]), 1);
    drain_req = 0;
    cyc();
    chk("drain released", int'(halted_o[0]), 0);
    chk("drain aw open", int'(m_aw_valid_o[0]), 1);
    cyc();
    chk("drain aw accepted", int'(wr_o[0]), 1);
    s_aw_valid = 0; m_aw_ready = 0;

    // Valid hold across drain
    do_reset();
    s_aw_valid = 1;
    settle();
    chk("hold presented", int'(m_aw_valid_o[0]), 1);
    cyc();
    drain_req = 1;
    cyc();
    chk("hold in drain", int'(m_aw_valid_o[0]), 1);
    cyc(); cyc();
    chk("hold still", int'(m_aw_valid_o[0]), 1);
    chk("hold not halted", int'(halted_o[0]), 0);
    m_aw_ready = 1;
    settle();
    chk("hold ready", int'(s_aw_ready_o[0]), 1);
    cyc();
    chk("hold wr 1", int'(wr_o[0]), 1);
    chk("hold closed after hs", int'(m_aw_valid_o[0]), 0);
    s_aw_valid = 0; m_aw_ready = 0;
    cyc();
    chk("hold waits for B", int'(halted_o[0]), 0);
    b_valid = 1; b_ready = 1;
    cyc();
    b_valid = 0; b_ready = 0;
    chk("hold halted after B", int'(halted_o[0]), 1);
    drain_req = 0;
    cyc();

    // Simultaneous events
    do_reset();
    s_aw_valid = 1; m_aw_ready = 1;
    cyc();
    chk("simul wr 1", int'(wr_o[0]), 1);
    b_valid = 1; b_ready = 1;
    cyc();
    chk("simul wr stays", int'(wr_o[0]), 1);
    idle_inputs();
    s_ar_valid = 1; m_ar_ready = 1;
    cyc();
    chk("simul rd 1", int'(rd_o[0]), 1);
    r_valid = 1; r_ready = 1; r_last = 1;
    cyc();
    chk("simul rd stays", int'(rd_o[0]), 1);
    chk("simul err", int'(err_o[0]), 0);
    idle_inputs();

    // Idle drain latency
    do_reset();
    drain_req = 1;
    cyc();
    chk("idle drain cycle 1", int'(halted_o[0]), 0);
    cyc();
    chk("idle drain cycle 2", int'(halted_o[0]), 1);
    drain_req = 0;
    cyc();
    chk("idle drain released", int'(halted_o[0]), 0);

    // Underflow and reset
    do_reset();
    b_valid = 1; b_ready = 1;
    cyc();
    b_valid = 0; b_ready = 0;
    chk("underflow err", int'(err_o[0]), 1);
    chk("underflow wr", int'(wr_o[0]), 0);
    cyc();
    chk("underflow sticky", int'(err_o[0]), 1);
    aresetn = 0;
    cyc();
    aresetn = 1;
    chk("reset clears err", int'(err_o[0]), 0);
    chk("reset clears halted", int'(halted_o[0]), 0);
    s_aw_valid = 1;
    settle();
    chk("reset run open", int'(m_aw_valid_o[0]), 1);
    cyc();
    idle_inputs();
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
